apb_gpio_slave: RTL

APB completer that terminates the transfers issued by the team's APB master/bridge. It exposes an 8-bit GPIO port through a small register file: output data, direction, synchronized input, and edge-interrupt registers. It inserts a programmable number of wait states and flags illegal accesses with PSLVERR. It sits on the far side of the APB bus, with gpio_* pins going to the pad ring.

---
 rtl/apb_gpio_slave.sv | 123 ++++++++++++
 1 files changed

// File: rtl/apb_gpio_slave.sv
// APB completer exposing an 8-bit GPIO port: output data, direction, synchronized
// input and edge interrupts, with programmable wait states and PSLVERR on bad accesses.
module apb_gpio_slave #(
  parameter int WAIT_STATES = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       PSEL,
  input  logic       PENABLE,
  input  logic       PWRITE,
  input  logic [3:0] PADDR,
  input  logic [7:0] PWDATA,
  output logic [7:0] PRDATA,
  output logic       PREADY,
  output logic       PSLVERR,
  input  logic [7:0] gpio_in,
  output logic [7:0] gpio_out,
  output logic [7:0] gpio_oe,
  output logic       irq
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  localparam logic [1:0] WS = 2'(WAIT_STATES);

  state_t state, state_nxt;
  logic [1:0] cnt, cnt_nxt;

  logic [7:0] dout, dir, ie, isr, pol, prev;
  logic [SYNC_STAGES-1:0][7:0] sync_q;
  logic [7:0] din;
  logic [7:0] edges, clr, rmux;
  logic       complete, err, wr_en;

  assign PREADY   = (state == ACCESS) && (cnt == WS);
  assign complete = PSEL && PENABLE && PREADY;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (PSEL && !PENABLE) state_nxt = SETUP;
      SETUP: begin
        if (!PSEL) state_nxt = IDLE;
        else begin
          state_nxt = ACCESS;
          cnt_nxt   = '0;
        end
      end
      ACCESS: begin
        if (!PSEL) state_nxt = IDLE;
        else if (complete) state_nxt = (PSEL && !PENABLE) ? SETUP : IDLE;
        else if (cnt < WS) cnt_nxt = cnt + 2'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // 0x2 is read-only; 0x6..0xF are unmapped
  assign err   = (PADDR > 4'd5) || (PWRITE && PADDR == 4'd2);
  assign wr_en = complete && PWRITE && !err;
  assign clr   = (wr_en && PADDR == 4'd4) ? PWDATA : 8'h00;

  assign din   = sync_q[SYNC_STAGES-1];
  assign edges = ((~pol & din & ~prev) | (pol & ~din & prev)) & ~dir;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      dout   <= '0;
      dir    <= '0;
      ie     <= '0;
      isr    <= '0;
      pol    <= '0;
      prev   <= '0;
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], gpio_in};
      prev   <= din;
      // a fresh edge outranks a same-cycle clear
      isr    <= (isr & ~clr) | edges;
      if (wr_en) begin
        case (PADDR)
          4'd0:    dout <= PWDATA;
          4'd1:    dir  <= PWDATA;
          4'd3:    ie   <= PWDATA;
          4'd5:    pol  <= PWDATA;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rmux = 8'h00;
    case (PADDR)
      4'd0:    rmux = dout;
      4'd1:    rmux = dir;
      4'd2:    rmux = din;
      4'd3:    rmux = ie;
      4'd4:    rmux = isr;
      4'd5:    rmux = pol;
      default: rmux = 8'h00;
    endcase
  end

  assign PRDATA   = PREADY ? rmux : 8'h00;
  assign PSLVERR  = complete && err;
  assign gpio_out = dout;
  assign gpio_oe  = dir;
  assign irq      = |(isr & ie);

endmodule
